// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store unit between the core controller and a valid/ready
//            memory/MMIO bus. Turns funct3-coded loads/stores into a single
//            aligned bus beat with byte enables, sign/zero-extends load data,
//            and reports misalignment, illegal width and bus timeout faults.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/req_ready - request handshake (ready only when idle)
//            req_write/funct3/addr/wdata - access description
//            resp_valid/rdata/fault - one-cycle response strobe
//            bus_valid/ready/write/addr/be/wdata/rdata - memory bus beat
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_fault,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_write,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int c_NB    = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_NB);
    localparam int c_WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Watchdog value at which one more stalled cycle means timeout.
    localparam logic [c_WD_W-1:0] c_WD_LAST = (TIMEOUT > 0) ? c_WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_bus_valid;
    logic                r_bus_write;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [c_NB-1:0]     r_bus_be;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic                r_write;
    logic [2:0]          r_funct3;
    logic [c_OFF_W-1:0]  r_off;
    logic [c_WD_W-1:0]   r_wd;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [1:0]          r_resp_fault;

    logic [1:0]          w_size;
    logic [2:0]          w_align_mask;
    logic [7:0]          w_be_base;
    logic                w_illegal;
    logic                w_misaligned;
    logic [c_OFF_W-1:0]  w_off;
    logic [c_NB-1:0]     w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_lane;
    logic                w_sign;
    logic [DATA_W-1:0]   w_load;
    logic                w_timeout;

    // ---------------------------------------------------------------- decode
    assign w_size = req_funct3[1:0];

    always_comb begin
        w_align_mask = 3'b000;
        w_be_base    = 8'h01;
        case (w_size)
            2'd0: begin w_align_mask = 3'b000; w_be_base = 8'h01; end
            2'd1: begin w_align_mask = 3'b001; w_be_base = 8'h03; end
            2'd2: begin w_align_mask = 3'b011; w_be_base = 8'h0F; end
            default: begin w_align_mask = 3'b111; w_be_base = 8'hFF; end
        endcase
    end

    assign w_illegal = ((w_size == 2'd3) && (DATA_W == 32))
                     || (!req_write && (req_funct3 == 3'b111))
                     || (!req_write && (req_funct3 == 3'b110) && (DATA_W == 32))
                     || (req_write && req_funct3[2]);
    assign w_misaligned = |(req_addr[2:0] & w_align_mask);

    assign w_off   = req_addr[c_OFF_W-1:0];
    assign w_be    = c_NB'(w_be_base) << w_off;
    assign w_wdata = req_wdata << {w_off, 3'b000};

    // ------------------------------------------------------- load extraction
    assign w_lane = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_sign = 1'b0;
        w_load = '0;
        case (r_funct3[1:0])
            2'd0:    w_sign = w_lane[7];
            2'd1:    w_sign = w_lane[15];
            2'd2:    w_sign = w_lane[31];
            default: w_sign = w_lane[DATA_W-1];
        endcase
        // funct3[2] selects the unsigned variant.
        w_sign = w_sign & ~r_funct3[2];
        for (int i = 0; i < c_NB; i++) begin
            w_load[8*i +: 8] = (i < (1 << r_funct3[1:0])) ? w_lane[8*i +: 8] : {8{w_sign}};
        end
    end

    // A ready in the same cycle the watchdog expires still completes the beat.
    assign w_timeout = (TIMEOUT > 0) && r_bus_valid && !bus_ready && (r_wd == c_WD_LAST);

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = (w_illegal || w_misaligned) ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (bus_ready || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_valid  <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
            r_write      <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= '0;
            r_wd         <= '0;
            r_resp_rdata <= '0;
            r_resp_fault <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wd         <= '0;
                    r_resp_rdata <= '0;
                    r_resp_fault <= 2'b00;
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_funct3 <= req_funct3;
                        r_off    <= w_off;
                        if (w_illegal) begin
                            r_resp_fault <= 2'b10;
                        end else if (w_misaligned) begin
                            r_resp_fault <= 2'b01;
                        end else begin
                            r_bus_valid <= 1'b1;
                            r_bus_write <= req_write;
                            r_bus_addr  <= {req_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                        end
                    end
                end
                S_BUS: begin
                    if (bus_ready || w_timeout) begin
                        r_bus_valid  <= 1'b0;
                        r_bus_write  <= 1'b0;
                        r_bus_addr   <= '0;
                        r_bus_be     <= '0;
                        r_bus_wdata  <= '0;
                        r_wd         <= '0;
                        r_resp_fault <= bus_ready ? 2'b00 : 2'b11;
                        r_resp_rdata <= (bus_ready && !r_write) ? w_load : '0;
                    end else begin
                        r_wd <= r_wd + c_WD_W'(1);
                    end
                end
                S_RESP: begin
                    r_resp_rdata <= '0;
                    r_resp_fault <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;
    assign bus_valid  = r_bus_valid;
    assign bus_write  = r_bus_write;
    assign bus_addr   = r_bus_addr;
    assign bus_be     = r_bus_be;
    assign bus_wdata  = r_bus_wdata;

endmodule
`default_nettype wire
